// File: rtl/y86_seq_controller.sv
// Multi-cycle stage sequencer for the Y86-64 sequential core: walks each instruction
// through the stages, handles the data-memory handshake, owns the status register and keeps run counters.
module y86_seq_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             halt_prog,
    input  logic             instr_valid,
    input  logic             pc_error,
    input  logic             mem_ack,
    input  logic             mem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             cc_en,
    output logic             mem_req,
    output logic [3:0]       stat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       dbg_state_o
);

    // Handshake: mem_req is held high for every MEMORY cycle; the access is complete
    // on the first cycle mem_ack is seen high, and mem_error is only meaningful with that ack.

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_STEP_HOLD = 4'd7,
        S_STOPPED   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       stat_q, stat_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d;
    logic             is_mem_op;

    assign is_mem_op = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                       (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            stat_q    <= STAT_AOK;
            tmo_q     <= '0;
            cyc_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            tmo_q     <= tmo_d;
            cyc_cnt_q <= cyc_cnt_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

    // Status is only ever written on the transition into STOPPED.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (pc_error) begin
                    state_d = S_STOPPED;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_STOPPED;
                    stat_d  = STAT_INS;
                end else if (halt_prog) begin
                    state_d = S_STOPPED;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = is_mem_op ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (mem_ack) begin
                    if (mem_error) begin
                        state_d = S_STOPPED;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_STOPPED;
                    stat_d  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = step_mode ? S_STEP_HOLD : S_FETCH;
            S_STEP_HOLD: begin
                if (step || !step_mode) state_d = S_FETCH;
            end
            S_STOPPED:   state_d = S_STOPPED;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        cc_en     = 1'b0;
        mem_req   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_FETCH: begin
                fetch_en = 1'b1;
                busy     = 1'b1;
            end
            S_DECODE: begin
                decode_en = 1'b1;
                busy      = 1'b1;
            end
            S_EXECUTE: begin
                exec_en = 1'b1;
                cc_en   = (icode == 4'h6);
                busy    = 1'b1;
            end
            S_MEMORY: begin
                mem_en  = 1'b1;
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            S_WRITEBACK: begin
                wb_en = 1'b1;
                busy  = 1'b1;
            end
            S_PCUPD: begin
                pc_en = 1'b1;
                busy  = 1'b1;
            end
            S_STOPPED: done = 1'b1;
            default: ;
        endcase
    end

    // Timeout counter runs only while in MEMORY, so it is zero on every entry.
    always_comb begin
        tmo_d = (state_q == S_MEMORY) ? tmo_q + TMO_W'(1) : '0;
        cyc_cnt_d = cyc_cnt_q;
        if (busy && (cyc_cnt_q != '1)) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        ins_cnt_d = ins_cnt_q;
        if ((state_q == S_PCUPD) && (ins_cnt_q != '1)) ins_cnt_d = ins_cnt_q + CNT_W'(1);
    end

    assign stat        = stat_q;
    assign cycle_count = cyc_cnt_q;
    assign instr_count = ins_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: directed instruction scenarios expand into per-cycle
// expected outputs, checked every cycle against the DUT, plus literal counter/status pins.
module tb_y86_seq_controller;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;

    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;
    localparam logic [5:0] EN_P = 6'b000001;

    logic             clk = 1'b0;
    logic             rst, start, step_mode, step;
    logic [3:0]       icode;
    logic             halt_prog, instr_valid, pc_error, mem_ack, mem_error;
    logic             fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic             cc_en, mem_req, busy, done;
    logic [3:0]       stat;
    logic [CNT_W-1:0] cycle_count, instr_count;
    logic [3:0]       dbg_state;

    y86_seq_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .icode(icode), .halt_prog(halt_prog), .instr_valid(instr_valid),
        .pc_error(pc_error), .mem_ack(mem_ack), .mem_error(mem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .cc_en(cc_en),
        .mem_req(mem_req), .stat(stat), .busy(busy), .done(done),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, start, step_mode, step, halt, valid, pcerr, ack, merr;
        logic [3:0] icode;
    } in_t;

    typedef struct packed {
        logic [5:0] en;
        logic       cc, req;
        logic [3:0] st;
        logic       busy, done, clr;
    } exp_t;

    exp_t        exp_q[$];
    in_t         nxt;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ins = 0;
    logic [3:0]  fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t run_e(input logic [5:0] en, input logic cc, input logic req);
        exp_t e;
        e.en = en; e.cc = cc; e.req = req; e.st = AOK;
        e.busy = 1'b1; e.done = 1'b0; e.clr = 1'b0;
        return e;
    endfunction

    function automatic exp_t idle_e(input logic clr);
        exp_t e;
        e.en = '0; e.cc = 1'b0; e.req = 1'b0; e.st = AOK;
        e.busy = 1'b0; e.done = 1'b0; e.clr = clr;
        return e;
    endfunction

    function automatic exp_t stop_e(input logic [3:0] st);
        exp_t e;
        e.en = '0; e.cc = 1'b0; e.req = 1'b0; e.st = st;
        e.busy = 1'b0; e.done = 1'b1; e.clr = 1'b0;
        return e;
    endfunction

    function automatic logic is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Compare process: one expected entry per cycle, counters modelled arithmetically.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.clr) begin
                    m_cyc = 0;
                    m_ins = 0;
                end
                chk("stage_en", {26'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en}, {26'd0, e.en});
                chk("cc_en", {31'd0, cc_en}, {31'd0, e.cc});
                chk("mem_req", {31'd0, mem_req}, {31'd0, e.req});
                chk("stat", {28'd0, stat}, {28'd0, e.st});
                chk("busy", {31'd0, busy}, {31'd0, e.busy});
                chk("done", {31'd0, done}, {31'd0, e.done});
                chk("cycle_count", cycle_count, m_cyc);
                chk("instr_count", instr_count, m_ins);
                if (e.busy && m_cyc != '1) m_cyc++;
                if (e.en == EN_P && m_ins != '1) m_ins++;
            end
        end
    end

    task automatic quiet();
        nxt.rst = 1'b0; nxt.start = 1'b0; nxt.step = 1'b0; nxt.halt = 1'b0;
        nxt.valid = 1'b1; nxt.pcerr = 1'b0; nxt.ack = 1'b0; nxt.merr = 1'b0;
    endtask

    task automatic cyc(input exp_t e);
        @(negedge clk);
        rst = nxt.rst; start = nxt.start; step_mode = nxt.step_mode; step = nxt.step;
        halt_prog = nxt.halt; instr_valid = nxt.valid; pc_error = nxt.pcerr;
        mem_ack = nxt.ack; mem_error = nxt.merr; icode = nxt.icode;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        quiet(); nxt.rst = 1'b1;
        cyc(idle_e(1'b1));
        cyc(idle_e(1'b1));
        quiet();
        cyc(idle_e(1'b0));
    endtask

    task automatic go();
        quiet(); nxt.start = 1'b1;
        cyc(idle_e(1'b0));
        quiet();
    endtask

    task automatic do_instr(input logic [3:0] ic, input int ack_cyc, input logic merr,
                            output logic [3:0] res);
        int nm;
        quiet(); nxt.icode = ic;
        cyc(run_e(EN_F, 1'b0, 1'b0));
        cyc(run_e(EN_D, 1'b0, 1'b0));
        cyc(run_e(EN_E, ic == 4'h6, 1'b0));
        res = AOK;
        if (is_mem(ic)) begin
            nm = (ack_cyc >= 1 && ack_cyc <= MEM_TIMEOUT) ? ack_cyc : MEM_TIMEOUT;
            for (int n = 1; n <= nm; n++) begin
                nxt.ack  = (n == ack_cyc);
                nxt.merr = (n == ack_cyc) ? merr : (n % 2 == 1);
                cyc(run_e(EN_M, 1'b0, 1'b1));
            end
            if (nm != ack_cyc || merr) res = ADR;
            quiet();
        end
        if (res == AOK) begin
            nxt.halt = 1'b1; nxt.pcerr = 1'b1; nxt.valid = 1'b0; nxt.ack = 1'b1;
            cyc(run_e(EN_W, 1'b0, 1'b0));
            cyc(run_e(EN_P, 1'b0, 1'b0));
            quiet();
        end
    endtask

    task automatic fetch_fault(input logic hp, input logic iv, input logic pe,
                               output logic [3:0] res);
        quiet(); nxt.halt = hp; nxt.valid = iv; nxt.pcerr = pe;
        cyc(run_e(EN_F, 1'b0, 1'b0));
        res = pe ? ADR : (!iv ? INS : (hp ? HLT : AOK));
        quiet();
    endtask

    task automatic stopped(input logic [3:0] st, input int n);
        logic [3:0] d0;
        d0 = '0;
        for (int i = 0; i < n; i++) begin
            quiet(); nxt.start = (i == 1); nxt.step = (i == 2); nxt.ack = 1'b1;
            cyc(stop_e(st));
            #1;
            if (i == 0) d0 = dbg_state;
            else chk("stopped_state_hold", {28'd0, dbg_state}, {28'd0, d0});
        end
        quiet();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            quiet(); nxt.start = 1'b1; nxt.ack = 1'b1; nxt.halt = 1'b1;
            cyc(idle_e(1'b0));
        end
        quiet();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; icode = 4'h0;
        halt_prog = 1'b0; instr_valid = 1'b1; pc_error = 1'b0;
        mem_ack = 1'b0; mem_error = 1'b0;
        nxt = '0;
        quiet();

        // Plain instruction, then a halt fetch.
        do_reset(); go();
        do_instr(4'h1, 0, 1'b0, fin);
        fetch_fault(1'b1, 1'b1, 1'b0, fin);
        stopped(fin, 4);
        #1;
        chk("t1_cycle_count", cycle_count, 32'd6);
        chk("t1_instr_count", instr_count, 32'd1);
        chk("t1_stat", {28'd0, stat}, 32'h4);

        // Memory instruction acked on the third MEMORY cycle, then an illegal fetch.
        do_reset(); go();
        do_instr(4'h4, 3, 1'b0, fin);
        fetch_fault(1'b0, 1'b0, 1'b0, fin);
        stopped(fin, 3);
        #1;
        chk("t2_cycle_count", cycle_count, 32'd9);
        chk("t2_instr_count", instr_count, 32'd1);
        chk("t2_stat", {28'd0, stat}, 32'h1);

        // cc_en on OPq only; pc_error outranks halt.
        do_reset(); go();
        do_instr(4'h6, 0, 1'b0, fin);
        do_instr(4'h2, 0, 1'b0, fin);
        fetch_fault(1'b1, 1'b1, 1'b1, fin);
        stopped(fin, 4);
        #1;
        chk("t3_instr_count", instr_count, 32'd2);
        chk("t3_stat", {28'd0, stat}, 32'h2);

        // Memory timeout.
        do_reset(); go();
        do_instr(4'h5, 0, 1'b0, fin);
        stopped(fin, 3);
        #1;
        chk("t4_cycle_count", cycle_count, 32'd19);
        chk("t4_instr_count", instr_count, 32'd0);
        chk("t4_stat", {28'd0, stat}, 32'h2);

        // Memory error with ack.
        do_reset(); go();
        do_instr(4'h9, 1, 1'b1, fin);
        stopped(fin, 3);
        #1;
        chk("t5_cycle_count", cycle_count, 32'd4);
        chk("t5_stat", {28'd0, stat}, 32'h2);

        // Single-step mode.
        do_reset();
        nxt.step_mode = 1'b1;
        go();
        do_instr(4'h1, 0, 1'b0, fin);
        hold(3);
        quiet(); nxt.step = 1'b1;
        cyc(idle_e(1'b0));
        do_instr(4'h1, 0, 1'b0, fin);
        hold(2);
        quiet(); nxt.step = 1'b1; nxt.step_mode = 1'b0;
        cyc(idle_e(1'b0));
        do_instr(4'hA, 1, 1'b0, fin);
        fetch_fault(1'b1, 1'b1, 1'b0, fin);
        stopped(fin, 3);
        #1;
        chk("t6_instr_count", instr_count, 32'd3);
        chk("t6_cycle_count", cycle_count, 32'd17);
        chk("t6_stat", {28'd0, stat}, 32'h4);

        // Asynchronous reset in the middle of a MEMORY cycle.
        do_reset(); go();
        quiet(); nxt.icode = 4'h8;
        cyc(run_e(EN_F, 1'b0, 1'b0));
        cyc(run_e(EN_D, 1'b0, 1'b0));
        cyc(run_e(EN_E, 1'b0, 1'b0));
        cyc(run_e(EN_M, 1'b0, 1'b1));
        cyc(run_e(EN_M, 1'b0, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("t7_enables", {26'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en}, 32'd0);
        chk("t7_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_stat", {28'd0, stat}, 32'h8);
        chk("t7_cycle_count", cycle_count, 32'd0);
        chk("t7_instr_count", instr_count, 32'd0);
        quiet(); nxt.rst = 1'b1;
        cyc(idle_e(1'b1));
        quiet();
        cyc(idle_e(1'b0));
        go();
        do_instr(4'h1, 0, 1'b0, fin);
        fetch_fault(1'b1, 1'b1, 1'b0, fin);
        stopped(fin, 2);

        @(negedge clk);
        #3;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
